// File: rtl/note_player_if.sv
// note_player_if: control, note RAM read port and codec audio-out signals of the note player
interface note_player_if #(
  parameter int ADDR_W   = 6,
  parameter int SAMPLE_W = 24
);
  logic                       start;
  logic                       stop;
  logic                       beat;
  logic [ADDR_W-1:0]          last_addr;
  logic [ADDR_W-1:0]          rd_addr;
  logic [31:0]                rd_data;
  logic                       audio_out_allowed;
  logic                       write_audio_out;
  logic signed [SAMPLE_W-1:0] audio_sample;
  logic [31:0]                note_out;
  logic                       playing;
  logic                       done;

  modport master (
    output start, stop, beat, last_addr, rd_data, audio_out_allowed,
    input  rd_addr, write_audio_out, audio_sample, note_out, playing, done
  );

  modport slave (
    input  start, stop, beat, last_addr, rd_data, audio_out_allowed,
    output rd_addr, write_audio_out, audio_sample, note_out, playing, done
  );
endinterface

// File: rtl/note_player.sv
// note_player: steps note RAM once per beat and plays each note as a square wave; PLAYER_LOOP_EN makes playback loop forever
module note_player #(
  parameter int                          CLK_HZ    = 50000000,
  parameter int                          ADDR_W    = 6,
  parameter int                          SAMPLE_W  = 24,
  parameter logic signed [SAMPLE_W-1:0]  AMPLITUDE = 24'sd4000000,
  parameter int                          HP_W      = 20
) (
  input logic          clk,
  input logic          reset,
  note_player_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

  localparam longint REF_HZ = 50000000;
  // half periods at 50 MHz, indexed by fret*6 + string
  localparam int unsigned BASE [30] = '{
    303373, 227273, 170262, 127552, 101238, 75843,
    286346, 214517, 160706, 120394,  95556, 71586,
    270274, 202477, 151686, 113636,  90193, 67569,
    255105, 191113, 143173, 107258,  85131, 63776,
    240787, 180386, 135137, 101238,  80353, 60197
  };

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       note_q, note_d;
  logic [HP_W-1:0]   cnt_q, cnt_d;
  logic              pol_q, pol_d;
  logic [HP_W-1:0]   hp_tab [30];
  logic [29:0]       bits;
  logic [4:0]        idx;
  logic              rest;
  logic [HP_W-1:0]   hp;

  for (genvar i = 0; i < 30; i++) begin : g_tab
    assign hp_tab[i] = HP_W'((longint'(BASE[i]) * CLK_HZ + REF_HZ / 2) / REF_HZ);
  end

  // tone lookup: lowest set bit of the incoming word in LOAD, of the held note otherwise
  always_comb begin
    bits = state_q == LOAD ? bus.rd_data[29:0] : note_q[29:0];
    idx = '0;
    for (int k = 29; k >= 0; k--) idx = bits[k] ? 5'(k) : idx;
    rest = bits == '0;
    hp = hp_tab[idx];
  end

  // next state, read address, held note and square-wave generator
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    note_d = note_q;
    cnt_d = cnt_q;
    pol_d = pol_q;
    if (state_q != IDLE && bus.stop) begin
      state_d = IDLE;
      note_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = bus.start ? FETCH : IDLE;
          addr_d = bus.start ? '0 : addr_q;
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          state_d = PLAY;
          note_d = bus.rd_data;
          cnt_d = hp - 1'b1;
          pol_d = 1'b1;
        end
        PLAY: begin
          if (!rest) begin
            cnt_d = cnt_q == '0 ? hp - 1'b1 : cnt_q - 1'b1;
            pol_d = cnt_q == '0 ? !pol_q : pol_q;
          end
          if (bus.beat) begin
            if (addr_q == bus.last_addr) begin
`ifdef PLAYER_LOOP_EN
              addr_d = '0;
              state_d = FETCH;
`else
              state_d = DONE;
`endif
            end else begin
              addr_d = addr_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          note_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      note_q <= '0;
      cnt_q <= '0;
      pol_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      note_q <= note_d;
      cnt_q <= cnt_d;
      pol_q <= pol_d;
    end
  end

  assign bus.rd_addr = addr_q;
  assign bus.note_out = note_q;
  assign bus.playing = state_q == FETCH || state_q == LOAD || state_q == PLAY;
  assign bus.done = state_q == DONE && !bus.stop;
  assign bus.write_audio_out = state_q != IDLE && bus.audio_out_allowed;
  assign bus.audio_sample = state_q == PLAY && !rest ? (pol_q ? AMPLITUDE : -AMPLITUDE) : '0;
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed checks of note_player with a 500 kHz tone table (A3 = 1136, A2 = 2273, E4 = 758 cycles)
module tb_note_player;
  localparam int ADDR_W = 6;
  localparam int SAMPLE_W = 24;
  localparam logic signed [SAMPLE_W-1:0] AMP = 24'sd4000000;

  logic        clk = 1'b0;
  logic        reset;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] ram [64];

  note_player_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

  note_player #(
    .CLK_HZ(500000), .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .AMPLITUDE(AMP), .HP_W(20)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic beat_once();
    bus.beat = 1'b1;
    tick(1);
    bus.beat = 1'b0;
  endtask

  initial begin
    int hi;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.beat = 1'b0;
    bus.last_addr = '0;
    bus.audio_out_allowed = 1'b1;
    tick(2);
    chk("reset rd_addr", bus.rd_addr, 0);
    chk("reset note_out", bus.note_out, 0);
    chk("reset playing", bus.playing, 0);
    chk("reset done", bus.done, 0);
    chk("reset write", bus.write_audio_out, 0);
    chk("reset sample", bus.audio_sample, 0);
    reset = 1'b0;
    tick(1);

    ram[0] = 32'h0000_8000;
    bus.last_addr = 6'd0;
    pulse_start();
    chk("t1 fetch playing", bus.playing, 1);
    chk("t1 fetch sample", bus.audio_sample, 0);
    tick(1);
    chk("t1 load sample", bus.audio_sample, 0);
    tick(1);
    chk("t1 first sample", bus.audio_sample, AMP);
    chk("t1 note_out", bus.note_out, 32'h8000);
    chk("t1 write", bus.write_audio_out, 1);
    tick(1135);
    chk("t1 c1136", bus.audio_sample, AMP);
    tick(1);
    chk("t1 c1137", bus.audio_sample, -AMP);
    tick(1135);
    chk("t1 c2272", bus.audio_sample, -AMP);
    tick(1);
    chk("t1 c2273", bus.audio_sample, AMP);
    beat_once();
    chk("t1 done", bus.done, 1);
    chk("t1 done playing", bus.playing, 0);
    chk("t1 done write", bus.write_audio_out, 1);
    tick(1);
    chk("t1 idle done", bus.done, 0);
    chk("t1 idle note", bus.note_out, 0);
    chk("t1 idle write", bus.write_audio_out, 0);

    ram[0] = 32'h2;
    ram[1] = 32'h0;
    ram[2] = 32'h20;
    bus.last_addr = 6'd2;
    pulse_start();
    tick(2);
    chk("t2 n0 addr", bus.rd_addr, 0);
    chk("t2 n0 note", bus.note_out, 32'h2);
    chk("t2 n0 first", bus.audio_sample, AMP);
    tick(2272);
    chk("t2 n0 c2273", bus.audio_sample, AMP);
    tick(1);
    chk("t2 n0 c2274", bus.audio_sample, -AMP);
    beat_once();
    chk("t2 n1 addr", bus.rd_addr, 1);
    chk("t2 fetch sample", bus.audio_sample, 0);
    tick(2);
    chk("t2 n1 note", bus.note_out, 0);
    chk("t2 n1 rest", bus.audio_sample, 0);
    tick(10);
    chk("t2 n1 rest later", bus.audio_sample, 0);
    chk("t2 n1 playing", bus.playing, 1);
    beat_once();
    chk("t2 n2 addr", bus.rd_addr, 2);
    tick(2);
    chk("t2 n2 note", bus.note_out, 32'h20);
    chk("t2 n2 first", bus.audio_sample, AMP);
    tick(757);
    chk("t2 n2 c758", bus.audio_sample, AMP);
    tick(1);
    chk("t2 n2 c759", bus.audio_sample, -AMP);
    beat_once();
    chk("t2 done", bus.done, 1);
    tick(1);
    chk("t2 idle", bus.playing, 0);

    ram[0] = 32'h0000_8002;
    ram[1] = 32'h0000_8000;
    bus.last_addr = 6'd1;
    pulse_start();
    tick(2);
    tick(1135);
    chk("t3 c1136", bus.audio_sample, AMP);
    tick(1);
    chk("t3 c1137", bus.audio_sample, AMP);
    tick(1136);
    chk("t3 c2273", bus.audio_sample, AMP);
    tick(1);
    chk("t3 c2274", bus.audio_sample, -AMP);
    bus.stop = 1'b1;
    bus.beat = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    bus.beat = 1'b0;
    #1;
    chk("t3 stop playing", bus.playing, 0);
    chk("t3 stop addr", bus.rd_addr, 0);
    chk("t3 stop write", bus.write_audio_out, 0);
    chk("t3 stop note", bus.note_out, 0);
    chk("t3 stop done", bus.done, 0);
    chk("t3 stop sample", bus.audio_sample, 0);
    tick(1);
    chk("t3 stop done next", bus.done, 0);

    ram[0] = 32'h0000_8000;
    bus.last_addr = 6'd0;
    pulse_start();
    tick(2);
    bus.audio_out_allowed = 1'b0;
    #1;
    hi = 0;
    repeat (100) begin
      hi += int'(bus.write_audio_out);
      tick(1);
    end
    chk("t4 write held low", hi, 0);
    bus.audio_out_allowed = 1'b1;
    #1;
    chk("t4 write resumes", bus.write_audio_out, 1);
    tick(1035);
    chk("t4 c1136", bus.audio_sample, AMP);
    tick(1);
    chk("t4 c1137", bus.audio_sample, -AMP);
    reset = 1'b1;
    #1;
    chk("t4 reset playing", bus.playing, 0);
    chk("t4 reset sample", bus.audio_sample, 0);
    chk("t4 reset write", bus.write_audio_out, 0);
    chk("t4 reset note", bus.note_out, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("t4 after reset", bus.playing, 0);

`ifdef PLAYER_LOOP_EN
    ram[0] = 32'h2;
    ram[1] = 32'h20;
    bus.last_addr = 6'd1;
    pulse_start();
    tick(2);
    chk("t5 addr 0", bus.rd_addr, 0);
    beat_once();
    chk("t5 addr 1", bus.rd_addr, 1);
    tick(2);
    beat_once();
    chk("t5 addr wrap", bus.rd_addr, 0);
    chk("t5 no done", bus.done, 0);
    chk("t5 still playing", bus.playing, 1);
    tick(2);
    beat_once();
    chk("t5 addr 1 again", bus.rd_addr, 1);
    tick(2);
    chk("t5 playing", bus.playing, 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
